// File: rtl/hazard_pkg.sv
// Shared types and encodings for the Osiris I pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned RES_W = 2;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN         = 2'b00,
        FENCE_DRAIN = 2'b01,
        FENCE_GO    = 2'b10
    } hz_state_t;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

    localparam logic [RES_W-1:0] RESULT_SRC_LOAD = 2'b01;

    // True when a writing stage targets a non-zero register equal to rs.
    function automatic logic reg_match(input logic             write_en,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs);
        return write_en && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX operand bypass select for one source register; MEM beats WB.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_mem,
    input  logic             reg_write_mem,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             reg_write_wb,
    output logic [FWD_W-1:0] forward_c
);

    always_comb begin
        forward_c = FWD_RF;
        if (reg_match(reg_write_mem, rd_mem, rs)) begin
            forward_c = FWD_MEM;
        end else if (reg_match(reg_write_wb, rd_wb, rs)) begin
            forward_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencer: operand forwarding plus stall/flush strobes for
// memory wait, taken branch, load-use and FENCE drain hazards.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned P_FENCE_DRAIN = 3,
    parameter int unsigned P_MEM_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_rs1_ID,
    input  logic [REG_W-1:0] i_rs2_ID,
    input  logic [REG_W-1:0] i_rs1_EX,
    input  logic [REG_W-1:0] i_rs2_EX,
    input  logic [REG_W-1:0] i_rd_EX,
    input  logic [REG_W-1:0] i_rd_MEM,
    input  logic [REG_W-1:0] i_rd_WB,
    input  logic             i_reg_write_MEM,
    input  logic             i_reg_write_WB,
    input  logic [RES_W-1:0] i_result_src_EX,
    input  logic             i_pc_src_EX,
    input  logic             i_fence_ID,
    input  logic             i_dmem_req_MEM,
    input  logic             i_dmem_ready,
    output logic [FWD_W-1:0] o_forward_a_EX,
    output logic [FWD_W-1:0] o_forward_b_EX,
    output logic             o_stall_IF,
    output logic             o_stall_ID,
    output logic             o_stall_EX,
    output logic             o_stall_MEM,
    output logic             o_flush_ID,
    output logic             o_flush_EX,
    output logic             o_flush_WB,
    output logic             o_fence_busy,
    output logic             o_dmem_timeout
);

    localparam int unsigned DRAIN_W = (P_FENCE_DRAIN > 1) ? $clog2(P_FENCE_DRAIN) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD  = DRAIN_W'(P_FENCE_DRAIN - 1);
    localparam logic [WAIT_W-1:0]  TIMEOUT_LIM = WAIT_W'(P_MEM_TIMEOUT);

    hz_state_t           state_q, state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;

    logic                mw_c, br_c, lu_c;
    logic [FWD_W-1:0]    fwd_a_c, fwd_b_c;

    forward_unit u_forward_a (
        .rs            (i_rs1_EX),
        .rd_mem        (i_rd_MEM),
        .reg_write_mem (i_reg_write_MEM),
        .rd_wb         (i_rd_WB),
        .reg_write_wb  (i_reg_write_WB),
        .forward_c     (fwd_a_c)
    );

    forward_unit u_forward_b (
        .rs            (i_rs2_EX),
        .rd_mem        (i_rd_MEM),
        .reg_write_mem (i_reg_write_MEM),
        .rd_wb         (i_rd_WB),
        .reg_write_wb  (i_reg_write_WB),
        .forward_c     (fwd_b_c)
    );

    // Raw hazard conditions, before priority resolution.
    always_comb begin
        mw_c = i_dmem_req_MEM && !i_dmem_ready;
        br_c = i_pc_src_EX;
        lu_c = (i_result_src_EX == RESULT_SRC_LOAD) && (i_rd_EX != '0) &&
               ((i_rd_EX == i_rs1_ID) || (i_rd_EX == i_rs2_ID));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // FENCE sequencing; a memory wait freezes the drain in place.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (i_fence_ID && !mw_c && !br_c) begin
                    state_d     = FENCE_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            FENCE_DRAIN: begin
                if (!mw_c) begin
                    if (br_c) begin
                        state_d = RUN;
                    end else if (drain_cnt_q == '0) begin
                        state_d = FENCE_GO;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    end
                end
            end
            FENCE_GO: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Memory wait counter saturates at the limit; the flag is sticky.
    always_comb begin
        wait_cnt_d = '0;
        if (mw_c) begin
            wait_cnt_d = (wait_cnt_q < TIMEOUT_LIM) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;
        end
        timeout_d = timeout_q || (wait_cnt_d == TIMEOUT_LIM);
    end

    // Priority: memory wait > branch > load-use > FENCE drain.
    always_comb begin
        o_forward_a_EX = fwd_a_c;
        o_forward_b_EX = fwd_b_c;
        o_stall_IF     = 1'b0;
        o_stall_ID     = 1'b0;
        o_stall_EX     = 1'b0;
        o_stall_MEM    = 1'b0;
        o_flush_ID     = 1'b0;
        o_flush_EX     = 1'b0;
        o_flush_WB     = 1'b0;
        o_fence_busy   = (state_q == FENCE_DRAIN);
        o_dmem_timeout = timeout_q;
        if (i_rst) begin
            o_forward_a_EX = FWD_RF;
            o_forward_b_EX = FWD_RF;
            o_flush_ID     = 1'b1;
            o_flush_EX     = 1'b1;
            o_flush_WB     = 1'b1;
            o_fence_busy   = 1'b0;
            o_dmem_timeout = 1'b0;
        end else if (mw_c) begin
            o_stall_IF  = 1'b1;
            o_stall_ID  = 1'b1;
            o_stall_EX  = 1'b1;
            o_stall_MEM = 1'b1;
            o_flush_WB  = 1'b1;
        end else if (br_c) begin
            o_flush_ID = 1'b1;
            o_flush_EX = 1'b1;
        end else if (lu_c || (state_q == FENCE_DRAIN)) begin
            o_stall_IF = 1'b1;
            o_stall_ID = 1'b1;
            o_flush_EX = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       wr_mem, wr_wb;
    logic [1:0] res_src;
    logic       pc_src, fence, dreq, drdy;
    logic [1:0] fwd_a, fwd_b;
    logic       s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, busy, tmo;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    // {stall IF,ID,EX,MEM, flush ID,EX,WB, fence_busy, timeout}
    localparam logic [8:0] O_IDLE  = 9'b0000_000_0_0;
    localparam logic [8:0] O_RST   = 9'b0000_111_0_0;
    localparam logic [8:0] O_LU    = 9'b1100_010_0_0;
    localparam logic [8:0] O_DRAIN = 9'b1100_010_1_0;
    localparam logic [8:0] O_BRDRN = 9'b0000_110_1_0;
    localparam logic [8:0] O_MW    = 9'b1111_001_0_0;
    localparam logic [8:0] O_MWTO  = 9'b1111_001_0_1;
    localparam logic [8:0] O_BRTO  = 9'b0000_110_0_1;
    localparam logic [8:0] O_BR    = 9'b0000_110_0_0;

    always #5 clk = ~clk;

    assign outs = {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, busy, tmo};

    hazard_unit #(.P_FENCE_DRAIN(3), .P_MEM_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_ID(rs1_id), .i_rs2_ID(rs2_id),
        .i_rs1_EX(rs1_ex), .i_rs2_EX(rs2_ex), .i_rd_EX(rd_ex),
        .i_rd_MEM(rd_mem), .i_rd_WB(rd_wb),
        .i_reg_write_MEM(wr_mem), .i_reg_write_WB(wr_wb),
        .i_result_src_EX(res_src), .i_pc_src_EX(pc_src),
        .i_fence_ID(fence), .i_dmem_req_MEM(dreq), .i_dmem_ready(drdy),
        .o_forward_a_EX(fwd_a), .o_forward_b_EX(fwd_b),
        .o_stall_IF(s_if), .o_stall_ID(s_id), .o_stall_EX(s_ex), .o_stall_MEM(s_mem),
        .o_flush_ID(f_id), .o_flush_EX(f_ex), .o_flush_WB(f_wb),
        .o_fence_busy(busy), .o_dmem_timeout(tmo)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
        rd_mem = 0; rd_wb = 0; wr_mem = 0; wr_wb = 0; res_src = 2'b00;
        pc_src = 0; fence = 0; dreq = 0; drdy = 0;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        rd_mem = 5; wr_mem = 1; rs1_ex = 5;
        cyc(); cyc();
        #2 chk("reset_outs", outs, O_RST);
        chk("reset_fwd_a", {7'd0, fwd_a}, 9'd0);

        rst = 1'b0; clear();
        cyc();
        #2 chk("idle_outs", outs, O_IDLE);

        // Forwarding: MEM beats WB, then WB only, disabled MEM write
        rd_mem = 5; wr_mem = 1; rd_wb = 5; wr_wb = 1; rs1_ex = 5; rs2_ex = 3;
        #2 chk("fwd_a_mem", {7'd0, fwd_a}, 9'b10);
        chk("fwd_b_none", {7'd0, fwd_b}, 9'b00);
        rd_mem = 0;
        #2 chk("fwd_a_wb_rd0", {7'd0, fwd_a}, 9'b01);
        rd_mem = 5; wr_mem = 0; rs2_ex = 5;
        #2 chk("fwd_b_wb_nowr", {7'd0, fwd_b}, 9'b01);
        rd_wb = 0;
        #2 chk("fwd_b_wb_rd0", {7'd0, fwd_b}, 9'b00);
        clear();

        // Load-use for one cycle, then bubble, then rd_EX = 0
        cyc();
        res_src = 2'b01; rd_ex = 7; rs2_id = 7;
        #2 chk("lu_stall", outs, O_LU);
        cyc();
        res_src = 2'b00; rd_ex = 0;
        #2 chk("lu_released", outs, O_IDLE);
        res_src = 2'b01; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        #2 chk("lu_rd0", outs, O_IDLE);
        clear();

        // FENCE drain: 3 busy cycles then one free cycle
        cyc();
        fence = 1;
        cyc();
        #2 chk("fence_drain1", outs, O_DRAIN);
        cyc();
        #2 chk("fence_drain2", outs, O_DRAIN);
        cyc();
        #2 chk("fence_drain3", outs, O_DRAIN);
        cyc();
        #2 chk("fence_go", outs, O_IDLE);
        fence = 0;
        cyc();
        #2 chk("fence_done", outs, O_IDLE);

        // Branch in 2nd drain cycle squashes the fence
        fence = 1;
        cyc();
        #2 chk("fbr_drain1", outs, O_DRAIN);
        cyc();
        pc_src = 1;
        #2 chk("fbr_branch", outs, O_BRDRN);
        cyc();
        fence = 0; pc_src = 0;
        #2 chk("fbr_run", outs, O_IDLE);

        // Fence alongside a branch never enters the drain
        fence = 1; pc_src = 1;
        #2 chk("fence_br_same", outs, O_BR);
        cyc();
        fence = 0; pc_src = 0;
        #2 chk("fence_br_noentry", outs, O_IDLE);

        // Memory wait holds a branch for 4 cycles; timeout=4 trips on the 4th
        dreq = 1; drdy = 0; pc_src = 1;
        for (int i = 0; i < 4; i++) begin
            #2 chk($sformatf("mw_br_%0d", i), outs, O_MW);
            cyc();
        end
        drdy = 1;
        #2 chk("mw_br_release", outs, O_BRTO);
        clear();

        rst = 1;
        cyc();
        rst = 0;
        #2 chk("post_rst_tmo", outs, O_IDLE);

        // Timeout: ready low 6 cycles, flag from 5th cycle, sticky
        dreq = 1; drdy = 0;
        for (int i = 0; i < 6; i++) begin
            #2 chk($sformatf("mw_to_%0d", i), outs, (i < 4) ? O_MW : O_MWTO);
            cyc();
        end
        drdy = 1;
        #2 chk("to_sticky1", outs, 9'b0000_000_0_1);
        cyc();
        dreq = 0;
        #2 chk("to_sticky2", outs, 9'b0000_000_0_1);
        rst = 1;
        #2 chk("to_in_rst", outs, O_RST);
        cyc();
        rst = 0;
        #2 chk("to_cleared", outs, O_IDLE);

        // Reset in the 2nd drain cycle abandons the fence
        fence = 1;
        cyc();
        #2 chk("rd_drain1", outs, O_DRAIN);
        cyc();
        rst = 1; fence = 0;
        #2 chk("rd_in_rst", outs, O_RST);
        cyc();
        rst = 0;
        #2 chk("rd_after_rst", outs, O_IDLE);
        cyc();
        #2 chk("rd_settled", outs, O_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
